// File: rtl/ddds_pkg.sv
// rtl/ddds_pkg.sv - shared types and defaults for the feature scorer and its streamer
package ddds_pkg;

    localparam int FEATURE_COUNT_DEF  = 136;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef logic [7:0] feature_t;
    typedef logic [7:0] index_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT,
        HOLD
    } streamer_state_t;

endpackage

// File: rtl/feature_buffer.sv
// rtl/feature_buffer.sv - feature vector storage, one sync write port and one async read port
module feature_buffer import ddds_pkg::*; #(
    parameter int FEATURE_COUNT = FEATURE_COUNT_DEF
) (
    input  logic       clk,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);

    // Deliberately unreset: contents must survive a streamer reset.
    feature_t mem [FEATURE_COUNT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/feature_streamer.sv
// rtl/feature_streamer.sv - buffers a feature vector, streams it to the scorer, captures the score
module feature_streamer import ddds_pkg::*; #(
    parameter int FEATURE_COUNT  = FEATURE_COUNT_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       go,
    output logic       busy,
    output logic       wr_drop,
    output logic       sc_start,
    output logic [7:0] sc_index,
    output logic [7:0] sc_data,
    input  logic       sc_done,
    input  logic [7:0] sc_result,
    output logic [7:0] result,
    output logic       result_valid,
    input  logic       result_ack,
    output logic       timeout
);

    localparam int              TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]      LAST_IDX = 8'(FEATURE_COUNT - 1);
    localparam logic [TW-1:0]   TLAST    = TW'(TIMEOUT_CYCLES - 1);

    streamer_state_t state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      result_q, result_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            to_q, to_d;
    logic            drop_q, drop_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            addr_ok;
    logic            buf_we;
    logic [7:0]      rd_data;

    assign addr_ok = {1'b0, wr_addr} < 9'(FEATURE_COUNT);
    assign buf_we  = wr_en && addr_ok && (state_q == IDLE);
    assign drop_d  = wr_en && !buf_we;

    // Read address is the next index, so sc_data registers alongside sc_index.
    assign data_d  = start_d ? rd_data : data_q;

    feature_buffer #(
        .FEATURE_COUNT(FEATURE_COUNT)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_d),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        tcnt_d   = tcnt_q;
        result_d = result_q;
        valid_d  = valid_q;
        to_d     = to_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = STREAM;
                    idx_d   = 8'd0;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            STREAM: begin
                if (idx_q == LAST_IDX) begin
                    state_d = WAIT;
                    tcnt_d  = '0;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    start_d = 1'b1;
                end
            end
            WAIT: begin
                // A done on the terminal-count cycle still counts as success.
                if (sc_done) begin
                    state_d  = HOLD;
                    result_d = sc_result;
                    to_d     = 1'b0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                end else if (tcnt_q == TLAST) begin
                    state_d  = HOLD;
                    result_d = 8'h00;
                    to_d     = 1'b1;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (result_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    to_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 8'd0;
            data_q   <= 8'd0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            tcnt_q   <= '0;
            result_q <= 8'd0;
            valid_q  <= 1'b0;
            to_q     <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            data_q   <= data_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            tcnt_q   <= tcnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            to_q     <= to_d;
            drop_q   <= drop_d;
        end
    end

    assign busy         = busy_q;
    assign wr_drop      = drop_q;
    assign sc_start     = start_q;
    assign sc_index     = idx_q;
    assign sc_data      = data_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_feature_streamer.sv
// tb/tb_feature_streamer.sv - scoreboard bench for feature_streamer with a stub scorer
module tb_feature_streamer;

    localparam int FC = 136;
    localparam int TO = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic       go = 1'b0;
    logic       sc_done = 1'b0;
    logic [7:0] sc_result = 8'd0;
    logic       result_ack = 1'b0;
    logic       busy, wr_drop, sc_start, result_valid, timeout;
    logic [7:0] sc_index, sc_data, result;

    feature_streamer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .go           (go),
        .busy         (busy),
        .wr_drop      (wr_drop),
        .sc_start     (sc_start),
        .sc_index     (sc_index),
        .sc_data      (sc_data),
        .sc_done      (sc_done),
        .sc_result    (sc_result),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        logic       to;
        logic [7:0] res;
    } res_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mdl [FC];
    logic [15:0] exp_stream [$];
    res_t        exp_res [$];
    int          exp_drops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops expectations whenever the DUT presents stream beats, drops or results.
    res_t        cur;
    logic        rv_q = 1'b0;
    logic        st_q = 1'b0;
    int          wait_cyc = 0;
    logic [15:0] e;

    always @(negedge clk) begin
        if (sc_start) begin
            wait_cyc = 0;
            if (exp_stream.size() == 0) begin
                fail_now("unexpected_sc_start");
            end else begin
                e = exp_stream.pop_front();
                check("stream_index", {24'd0, sc_index}, {24'd0, e[15:8]});
                check("stream_data", {24'd0, sc_data}, {24'd0, e[7:0]});
            end
        end else begin
            if (st_q) check("stream_gap_remaining", exp_stream.size(), 0);
            if (busy) wait_cyc++;
        end
        st_q = sc_start;
        if (wr_drop) begin
            check("wr_drop_expected", {31'd0, exp_drops > 0}, 32'd1);
            if (exp_drops > 0) exp_drops--;
        end
        if (result_valid && !rv_q) begin
            if (exp_res.size() == 0) begin
                fail_now("unexpected_result_valid");
            end else begin
                cur = exp_res.pop_front();
                check("result", {24'd0, result}, {24'd0, cur.res});
                check("timeout", {31'd0, timeout}, {31'd0, cur.to});
                check("wait_latency", wait_cyc, cur.lat);
            end
        end else if (result_valid) begin
            check("result_stable", {24'd0, result}, {24'd0, cur.res});
            check("timeout_stable", {31'd0, timeout}, {31'd0, cur.to});
        end
        rv_q = result_valid;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_wr_drop"}, {31'd0, wr_drop}, 0);
        check({tag, "_sc_start"}, {31'd0, sc_start}, 0);
        check({tag, "_sc_index"}, {24'd0, sc_index}, 0);
        check({tag, "_sc_data"}, {24'd0, sc_data}, 0);
        check({tag, "_result"}, {24'd0, result}, 0);
        check({tag, "_result_valid"}, {31'd0, result_valid}, 0);
        check({tag, "_timeout"}, {31'd0, timeout}, 0);
    endtask

    task automatic write(input logic [7:0] addr, input logic [7:0] data, input bit expect_drop);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        if (expect_drop) exp_drops++;
        else mdl[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Called at a negedge; go is sampled at the following rising edge.
    task automatic start_stream();
        go = 1'b1;
        for (int i = 0; i < FC; i++) exp_stream.push_back({8'(i), mdl[i]});
        @(negedge clk);
        go = 1'b0;
        check("first_beat_start", {31'd0, sc_start}, 1);
    endtask

    task automatic await_wait();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (busy && !sc_start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("await_wait_timeout");
    endtask

    // Stub scorer: done sampled j edges after WAIT entry; a stray go is pulsed in WAIT.
    task automatic scorer(input int j, input logic [7:0] res);
        res_t r;
        r.lat = j; r.to = 1'b0; r.res = res;
        exp_res.push_back(r);
        await_wait();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < j - 2; i++) @(negedge clk);
        sc_done   = 1'b1;
        sc_result = res;
        @(negedge clk);
        sc_done   = 1'b0;
        sc_result = 8'h00;
    endtask

    task automatic wait_result();
        bit ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("wait_result_timeout");
    endtask

    task automatic ack(input bit go_too);
        result_ack = 1'b1;
        go         = go_too;
        @(negedge clk);
        result_ack = 1'b0;
        go         = 1'b0;
        check("ack_clears_valid", {31'd0, result_valid}, 0);
        check("ack_clears_timeout", {31'd0, timeout}, 0);
        check("ack_no_restart", {31'd0, sc_start}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t r;
        bit   hit;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        for (int i = 0; i < FC; i++) write(8'(i), 8'(i), 1'b0);
        write(8'd136, 8'h77, 1'b1);

        // Capture with stray go and a rejected write mid-stream.
        @(negedge clk);
        start_stream();
        repeat (10) @(negedge clk);
        go = 1'b1; wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'hEE; exp_drops++;
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        scorer(137, 8'hA5);
        wait_result();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        ack(1'b0);

        // Timeout, then ack together with go, then go on the next cycle.
        @(negedge clk);
        start_stream();
        r.lat = TO; r.to = 1'b1; r.res = 8'h00;
        exp_res.push_back(r);
        await_wait();
        wait_result();
        repeat (2) @(negedge clk);
        ack(1'b1);
        start_stream();
        scorer(TO, 8'h3C);
        wait_result();
        @(negedge clk);
        ack(1'b0);

        // Reset mid-stream, then restart from index 0 with retained buffer.
        @(negedge clk);
        start_stream();
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sc_start && sc_index == 8'd60) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) fail_now("reach_index_60");
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_stream.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_stream();
        scorer(2, 8'h5A);
        wait_result();
        @(negedge clk);
        ack(1'b0);

        repeat (3) @(negedge clk);
        check("stream_queue_empty", exp_stream.size(), 0);
        check("result_queue_empty", exp_res.size(), 0);
        check("drops_all_seen", exp_drops, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
